// File: rtl/decap_packet.sv
// Reassembles header-tagged Aurora flits into one DFX data+address word and holds
// the word until the consumer takes it; a stalled partial word closes after IDLE_TIMEOUT.
module decap_packet #(
  parameter int DATA_WIDTH             = 1024,
  parameter int ADDR_WIDTH             = 10,
  parameter int DATA_DFX_WIDTH         = DATA_WIDTH + ADDR_WIDTH,
  parameter int RECOGNIZE_ROUTER_WIDTH = 2,
  parameter int NUMBER_PACKET          = 19,
  parameter int TTL_WIDTH              = $clog2(3),
  parameter int HEADER_WIDTH           = RECOGNIZE_ROUTER_WIDTH + $clog2(NUMBER_PACKET) + TTL_WIDTH,
  parameter int AURORA_DATA_WIDTH      = 64,
  parameter int PAYLOAD_WIDTH          = AURORA_DATA_WIDTH - HEADER_WIDTH,
  parameter int IDLE_TIMEOUT           = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [AURORA_DATA_WIDTH-1:0]      data_out_port_0,
  input  logic                              data_decap_valid,
  output logic                              ready_decap,
  output logic [DATA_DFX_WIDTH-1:0]         data_dfx_recv,
  output logic                              data_dfx_valid,
  input  logic                              data_dfx_ready,
  output logic [RECOGNIZE_ROUTER_WIDTH-1:0] router_id_recv,
  output logic [TTL_WIDTH-1:0]              ttl_recv,
  output logic                              seq_err
);

  localparam int BUF_W  = DATA_WIDTH + ADDR_WIDTH;
  localparam int IDX_W  = $clog2(NUMBER_PACKET);
  localparam int CNT_W  = $clog2(IDLE_TIMEOUT + 1);
  localparam int IDX_LO = RECOGNIZE_ROUTER_WIDTH;
  localparam int TTL_LO = IDX_LO + IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_HOLD} state_t;

  state_t                            state_q, state_d;
  logic [BUF_W-1:0]                  buf_q, buf_d;
  logic [IDX_W-1:0]                  exp_idx;
  logic [CNT_W-1:0]                  idle_cnt;
  logic                              xfer, start, wr, buf_clr, err;

  logic [RECOGNIZE_ROUTER_WIDTH-1:0] flit_rid;
  logic [IDX_W-1:0]                  flit_idx;
  logic [TTL_WIDTH-1:0]              flit_ttl;
  logic [PAYLOAD_WIDTH-1:0]          flit_pay;

  assign flit_rid = data_out_port_0[RECOGNIZE_ROUTER_WIDTH-1:0];
  assign flit_idx = data_out_port_0[IDX_LO +: IDX_W];
  assign flit_ttl = data_out_port_0[TTL_LO +: TTL_WIDTH];
  assign flit_pay = data_out_port_0[AURORA_DATA_WIDTH-1:HEADER_WIDTH];

  assign ready_decap    = !rst && (state_q != S_HOLD);
  assign xfer           = data_decap_valid && ready_decap;
  assign data_dfx_valid = (state_q == S_HOLD);
  assign data_dfx_recv  = data_dfx_valid ? buf_q : '0;

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    wr      = 1'b0;
    buf_clr = 1'b0;
    err     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          if (flit_idx == '0) begin
            start   = 1'b1;
            state_d = S_COLLECT;
          end else begin
            err = 1'b1;
          end
        end
      end
      S_COLLECT: begin
        if (xfer) begin
          if (flit_idx == exp_idx) begin
            wr = 1'b1;
            if (flit_idx == IDX_W'(NUMBER_PACKET - 1)) state_d = S_HOLD;
          end else begin
            err = 1'b1;
            if (flit_idx == '0) begin
              start = 1'b1;
            end else begin
              buf_clr = 1'b1;
              state_d = S_IDLE;
            end
          end
        end else if (idle_cnt == CNT_W'(IDLE_TIMEOUT - 1)) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (data_dfx_ready) begin
          buf_clr = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Per-flit slice write; the last flit carries only the bits that fit the word.
  for (genvar i = 0; i < NUMBER_PACKET; i++) begin : g_slice
    localparam int LO = i * PAYLOAD_WIDTH;
    localparam int SW = (LO + PAYLOAD_WIDTH > BUF_W) ? (BUF_W - LO) : PAYLOAD_WIDTH;
    assign buf_d[LO +: SW] = ((start || wr) && flit_idx == IDX_W'(i)) ? flit_pay[SW-1:0] :
                             (buf_clr || start)                        ? '0 :
                                                                         buf_q[LO +: SW];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      buf_q          <= '0;
      exp_idx        <= '0;
      idle_cnt       <= '0;
      router_id_recv <= '0;
      ttl_recv       <= '0;
      seq_err        <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      seq_err <= err;
      if (start) begin
        exp_idx        <= IDX_W'(1);
        router_id_recv <= flit_rid;
        ttl_recv       <= flit_ttl;
      end else if (wr) begin
        exp_idx <= exp_idx + 1'b1;
      end else if (buf_clr) begin
        exp_idx <= '0;
      end
      if (xfer || state_q != S_COLLECT) idle_cnt <= '0;
      else                              idle_cnt <= idle_cnt + 1'b1;
    end
  end

endmodule
